hs_ram_arbiter: RTL and testbench
=================================

// Module: hs_ram_arbiter
// PURPOSE
//  Shares the game work-RAM secondary port (hiscore address/data/write path) between two
//  requesters: req 0 = hiscore save/restore engine, req 1 = OSD/debug RAM dumper.
//  Pauses the core, waits for vertical blank plus a settle time, then grants one owner.
//  Sequences owner hand-over, drains in-flight reads, and releases pause. Merges the user pause.
// PARAMETERS
//  AW      16  RAM address width
//  DW      8   RAM data width
//  SETTLE  4   cycles core_pause is held after vblank before first grant (0 = none)
//  RD_LAT  1   RAM read latency in cycles, address to ram_rdata (1..3)
// PORTS
//  clk            in   1       system clock; sole clock
//  reset_n        in   1       synchronous reset, active low
//  vblank         in   1       core vertical blank
//  ext_pause      in   1       user pause toggle, merged into core_pause
//  req            in   2       per-requester ownership request, level, held while owning
//  gnt            out  2       per-requester grant, one-hot or zero, registered
//  cmd_valid      in   2       per-requester access strobe, honoured only while own gnt=1
//  cmd_we         in   2       1 = write, 0 = read
//  cmd_addr       in   2*AW    per-requester address; [AW-1:0] = req 0
//  cmd_wdata      in   2*DW    per-requester write data
//  rd_valid       out  2       read data valid, routed to the issuing requester
//  rd_data        out  DW      = ram_rdata (shared)
//  ram_addr       out  AW      RAM address, registered
//  ram_wdata      out  DW      RAM write data, registered
//  ram_we         out  1       RAM write pulse, registered
//  ram_rdata      in   DW      RAM read data
//  core_pause     out  1       ext_pause | arb_pause; arb_pause registered
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge):
//   - State = IDLE. gnt, ram_we, arb_pause, rd_valid, ram_addr and ram_wdata = 0.
//   - last_owner = 1. Read pipeline flushed.
//   - Overrides any state. In-flight reads are discarded without rd_valid.
//  States: IDLE, PAUSE_WAIT, SETTLE, GRANT, DRAIN.
//  IDLE, arb_pause=0:
//   - Any req bit set -> PAUSE_WAIT next cycle; arb_pause=1 from that cycle.
//   - Owner is chosen at this transition. Single request: that requester.
//   - Both requests: the requester != last_owner (round robin).
//  PAUSE_WAIT:
//   - Stays until vblank is sampled 1.
//   - Then -> SETTLE with cnt=SETTLE-1, or -> GRANT if SETTLE=0.
//  SETTLE:
//   - cnt decrements each cycle; cnt=0 -> GRANT. gnt[owner]=1 in the first GRANT cycle.
//  Owner request drops in PAUSE_WAIT or SETTLE:
//   - If the other requester is requesting, it becomes owner and the state is kept.
//   - Otherwise -> IDLE and arb_pause=0 next cycle.
//  GRANT:
//   - cmd_valid[owner] at cycle N drives ram_addr/ram_wdata at N+1.
//   - Write: ram_we=1 for exactly cycle N+1.
//   - Read: rd_valid[owner]=1 at cycle N+1+RD_LAT, one cycle wide.
//   - Back-to-back commands are accepted every cycle.
//   - cmd_valid from the non-owner, or with gnt=0, is ignored: no RAM activity.
//   - ram_addr and ram_wdata hold their last value when idle.
//   - req[owner]=0 -> gnt=0 next cycle, state DRAIN, last_owner=owner.
//     A cmd_valid in that same cycle is still executed.
//  DRAIN, gnt=0, arb_pause held at 1:
//   - Waits until the read pipeline is empty; 1 cycle minimum.
//   - Then, if the other req is high -> GRANT to it directly, with no vblank wait or settle.
//   - Otherwise -> IDLE with arb_pause=0.
//  Rules:
//   - gnt is never asserted while arb_pause=0.
//   - Never two gnt bits at once.
//   - core_pause follows ext_pause combinationally.
//   - ext_pause does not bypass the vblank wait.
//   - The read pipeline tags each read with its requester index.
//     A requester dropping req does not lose read data already in flight.
// TESTING
//  1. req0=1 from cycle 0, vblank=1 at cycle 5, SETTLE=4:
//     -> core_pause=1 at cycle 1, gnt=01 at cycle 10 (expected sequence to be confirmed
//     against RTL during bring-up).
//  2. gnt0, write 0x43A5<-0x7E then read 0x43A5 on the next cycle:
//     -> ram_we pulse with 0x43A5/0x7E; rd_valid[0] 2 cycles after the read with rd_data=0x7E.
//  3. req=11 from IDLE after reset -> req0 is granted first.
//     On req0 drop -> DRAIN 1 cycle, then gnt=10 with no vblank wait; core_pause stays 1.
//  4. req0 drops in the same cycle as a read, RD_LAT=3:
//     -> DRAIN lasts until rd_valid[0] fires, then IDLE and core_pause=0 (ext_pause=0).
//  5. cmd_valid[1]=1 while gnt=01, or cmd_valid[0]=1 while gnt=00:
//     -> ram_we stays 0, no rd_valid, ram_addr unchanged.
//  6. reset_n=0 for one cycle mid-GRANT with a read in flight:
//     -> gnt=00, core_pause=ext_pause, no rd_valid, state IDLE.

Source files
------------

// File: rtl/hs_ram_arbiter.sv
// Arbiter for the work-RAM secondary port shared by the hiscore engine (req 0)
// and the OSD/debug dumper (req 1). Pauses the core, waits for vblank plus a
// settle delay, grants one owner, drains in-flight reads on release and hands
// over or releases the pause.
module hs_ram_arbiter #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vblank,
    input  logic            ext_pause,
    input  logic [1:0]      req,
    output logic [1:0]      gnt,
    input  logic [1:0]      cmd_valid,
    input  logic [1:0]      cmd_we,
    input  logic [2*AW-1:0] cmd_addr,
    input  logic [2*DW-1:0] cmd_wdata,
    output logic [1:0]      rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    output logic            ram_we,
    input  logic [DW-1:0]   ram_rdata,
    output logic            core_pause
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CntInit = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {StIdle, StPauseWait, StSettle, StGrant, StDrain} state_e;

    state_e              state_q;
    logic                owner_q;
    logic                last_owner_q;
    logic                arb_pause_q;
    logic [CW-1:0]       cnt_q;
    // Read tag pipeline: two bits (one per requester) per stage, newest in [1:0]
    logic [2*RD_LAT+1:0] rd_sr_q;

    logic          other;
    logic          own_req;
    logic          oth_req;
    logic          pick;
    logic [1:0]    own_oh;
    logic [1:0]    oth_oh;
    logic [1:0]    take_vec;
    logic          take;
    logic          take_we;
    logic [1:0]    issue_vec;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          drain_busy;

    // Request decode, owner selection and command acceptance
    always_comb begin
        other     = ~owner_q;
        own_req   = req[owner_q];
        oth_req   = req[other];
        // With both requesting, the one that did not own last goes first
        pick      = (req == 2'b11) ? ~last_owner_q : req[1];
        own_oh    = 2'b01 << owner_q;
        oth_oh    = 2'b01 << other;
        // gnt is one-hot, so this only ever passes the owner's strobe
        take_vec  = gnt & cmd_valid;
        take      = |take_vec;
        take_we   = cmd_we[owner_q];
        issue_vec = take_vec & ~cmd_we;
        sel_addr  = owner_q ? cmd_addr[2*AW-1:AW] : cmd_addr[AW-1:0];
        sel_wdata = owner_q ? cmd_wdata[2*DW-1:DW] : cmd_wdata[DW-1:0];
        // Reads still to come after this cycle; the oldest stage is on rd_valid now
        drain_busy = |rd_sr_q[2*RD_LAT-1:0];
    end

    assign rd_valid   = rd_sr_q[2*RD_LAT +: 2];
    assign rd_data    = ram_rdata;
    assign core_pause = ext_pause | arb_pause_q;

    // Arbitration FSM, RAM command register and read tag pipeline
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            arb_pause_q  <= 1'b0;
            cnt_q        <= '0;
            gnt          <= 2'b00;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            rd_sr_q      <= '0;
        end else begin
            ram_we  <= take & take_we;
            rd_sr_q <= {rd_sr_q[2*RD_LAT-1:0], issue_vec};
            if (take) begin
                ram_addr  <= sel_addr;
                ram_wdata <= sel_wdata;
            end

            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        owner_q     <= pick;
                        state_q     <= StPauseWait;
                        arb_pause_q <= 1'b1;
                    end
                end
                StPauseWait: begin
                    if (!own_req) begin
                        if (oth_req) begin
                            owner_q <= other;
                        end else begin
                            state_q     <= StIdle;
                            arb_pause_q <= 1'b0;
                        end
                    end else if (vblank) begin
                        if (SETTLE == 0) begin
                            state_q <= StGrant;
                            gnt     <= own_oh;
                        end else begin
                            state_q <= StSettle;
                            cnt_q   <= CntInit;
                        end
                    end
                end
                StSettle: begin
                    if (!own_req) begin
                        if (oth_req) begin
                            owner_q <= other;
                        end else begin
                            state_q     <= StIdle;
                            arb_pause_q <= 1'b0;
                        end
                    end else if (cnt_q == '0) begin
                        state_q <= StGrant;
                        gnt     <= own_oh;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StGrant: begin
                    if (!own_req) begin
                        gnt          <= 2'b00;
                        state_q      <= StDrain;
                        last_owner_q <= owner_q;
                    end
                end
                StDrain: begin
                    if (!drain_busy) begin
                        // Core is already paused and RAM quiet: hand over without vblank
                        if (oth_req) begin
                            owner_q <= other;
                            gnt     <= oth_oh;
                            state_q <= StGrant;
                        end else begin
                            state_q     <= StIdle;
                            arb_pause_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: two instances (RD_LAT 1 and 3) share stimulus and
// are checked each cycle against a behavioural model, plus directed vectors.
module tb_hs_ram_arbiter;

    localparam int SET = 4;
    localparam int P_IDLE = 0, P_WAITVB = 1, P_SETTLE = 2, P_OWN = 3, P_DRAIN = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vblank = 1'b0;
    logic        ext_pause = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  cmd_valid = 2'b00;
    logic [1:0]  cmd_we = 2'b00;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;

    logic [1:0]  g1, g3, rv1, rv3;
    logic [7:0]  rd1, rd3, wd1, wd3, rr1, rr3;
    logic [15:0] a1, a3;
    logic        we1, we3, cp1, cp3;

    always #5 clk = ~clk;

    hs_ram_arbiter u_dut1 (
        .clk(clk), .reset_n(reset_n), .vblank(vblank), .ext_pause(ext_pause), .req(req),
        .gnt(g1), .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rd_valid(rv1), .rd_data(rd1), .ram_addr(a1),
        .ram_wdata(wd1), .ram_we(we1), .ram_rdata(rr1), .core_pause(cp1)
    );

    hs_ram_arbiter #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .vblank(vblank), .ext_pause(ext_pause), .req(req),
        .gnt(g3), .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rd_valid(rv3), .rd_data(rd3), .ram_addr(a3),
        .ram_wdata(wd3), .ram_we(we3), .ram_rdata(rr3), .core_pause(cp3)
    );

    function automatic logic [7:0] pat(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Behavioural RAMs: latency 1 and 3, preloaded with pat() on the first edge
    logic [7:0] ram1 [65536];
    logic [7:0] ram3 [65536];
    logic [7:0] rp3 [3];
    bit         ram_init = 1'b0;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int a = 0; a < 65536; a++) begin
                ram1[a] <= pat(16'(a));
                ram3[a] <= pat(16'(a));
            end
            ram_init <= 1'b1;
        end else begin
            if (we1) ram1[a1] <= wd1;
            if (we3) ram3[a3] <= wd3;
        end
        rr1    <= ram1[a1];
        rp3[0] <= ram3[a3];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign rr3 = rp3[2];

    // Reference model state, index 0 = RD_LAT 1 instance, 1 = RD_LAT 3 instance
    typedef struct {
        int         inst;
        int         due;
        logic       who;
        logic [7:0] data;
    } rd_t;

    rd_t         rq[$];
    logic [7:0]  mm [int];
    int          ph [2];
    int          cnt [2];
    logic        own [2];
    logic        lst [2];
    logic [1:0]  eg [2];
    logic        eap [2];
    logic        ewe [2];
    logic [15:0] ead [2];
    logic [7:0]  ewd [2];

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    function automatic int lat(int m);
        return (m == 1) ? 3 : 1;
    endfunction

    function automatic logic [7:0] mem_rd(int m, logic [15:0] a);
        int k = m * 65536 + int'(a);
        return mm.exists(k) ? mm[k] : pat(a);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock edge of the model, using the inputs held during cycle cyc
    task automatic model_step(int m);
        int          t;
        logic        o;
        logic        pend;
        logic [15:0] a;
        logic [7:0]  w;
        t = cyc;
        if (!reset_n) begin
            ph[m] = P_IDLE; cnt[m] = 0; own[m] = 1'b0; lst[m] = 1'b1;
            eg[m] = 2'b00; eap[m] = 1'b0; ewe[m] = 1'b0; ead[m] = '0; ewd[m] = '0;
            for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].inst == m) rq.delete(i);
            return;
        end
        o = own[m];
        ewe[m] = 1'b0;
        if (eg[m][o] && cmd_valid[o]) begin
            a = o ? cmd_addr[31:16] : cmd_addr[15:0];
            w = o ? cmd_wdata[15:8] : cmd_wdata[7:0];
            ead[m] = a;
            ewd[m] = w;
            if (cmd_we[o]) begin
                ewe[m] = 1'b1;
                mm[m * 65536 + int'(a)] = w;
            end else begin
                rq.push_back('{inst: m, due: t + 1 + lat(m), who: o, data: mem_rd(m, a)});
            end
        end
        pend = 1'b0;
        foreach (rq[i]) if (rq[i].inst == m && rq[i].due > t) pend = 1'b1;
        case (ph[m])
            P_IDLE: if (req != 2'b00) begin
                own[m] = (req == 2'b11) ? !lst[m] : req[1];
                ph[m] = P_WAITVB;
                eap[m] = 1'b1;
            end
            P_WAITVB, P_SETTLE: begin
                if (!req[o]) begin
                    if (req[!o]) own[m] = !o;
                    else begin ph[m] = P_IDLE; eap[m] = 1'b0; end
                end else if (ph[m] == P_WAITVB) begin
                    if (vblank) begin
                        if (SET == 0) begin ph[m] = P_OWN; eg[m] = o ? 2'b10 : 2'b01; end
                        else begin ph[m] = P_SETTLE; cnt[m] = SET - 1; end
                    end
                end else if (cnt[m] == 0) begin
                    ph[m] = P_OWN; eg[m] = o ? 2'b10 : 2'b01;
                end else begin
                    cnt[m]--;
                end
            end
            P_OWN: if (!req[o]) begin eg[m] = 2'b00; ph[m] = P_DRAIN; lst[m] = o; end
            P_DRAIN: if (!pend) begin
                if (req[!o]) begin own[m] = !o; ph[m] = P_OWN; eg[m] = o ? 2'b01 : 2'b10; end
                else begin ph[m] = P_IDLE; eap[m] = 1'b0; end
            end
            default: ;
        endcase
    endtask

    // Advance one cycle and compare both instances with the model
    task automatic tick();
        logic [1:0]  erv;
        logic [7:0]  erd;
        logic [29:0] act;
        logic [7:0]  ard;
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
        for (int m = 0; m < 2; m++) begin
            erv = 2'b00;
            erd = '0;
            foreach (rq[i]) if (rq[i].inst == m && rq[i].due == cyc) begin
                erv[rq[i].who] = 1'b1;
                erd = rq[i].data;
            end
            if (m == 0) begin act = {g1, rv1, we1, cp1, a1, wd1}; ard = rd1; end
            else        begin act = {g3, rv3, we3, cp3, a3, wd3}; ard = rd3; end
            chk($sformatf("model_m%0d", m), act,
                {eg[m], erv, ewe[m], ext_pause | eap[m], ead[m], ewd[m]});
            if (erv != 2'b00) chk($sformatf("rdata_m%0d", m), ard, erd);
        end
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due <= cyc) rq.delete(i);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = 2'b00; cmd_valid = 2'b00; vblank = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("reset_d1", {g1, rv1, we1, cp1, a1, wd1}, {6'b0, ext_pause, 24'h0});
        chk("reset_d3", {g3, rv3, we3, cp3, a3, wd3}, {6'b0, ext_pause, 24'h0});
    endtask

    task automatic get_grant(logic [1:0] r, logic [1:0] want, string nm);
        req = r;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        for (int i = 0; i < 20 && g1 == 2'b00; i++) tick();
        chk(nm, g1, want);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        vb;
        logic [1:0]  cv;
        logic [1:0]  we;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [7:0]  wd;
        logic [1:0]  e_gnt;
        logic        e_cp;
        logic        e_we;
        logic [1:0]  e_rv;
        logic [15:0] e_addr;
        logic [7:0]  e_wd;
        logic [7:0]  e_rd;
    } vec_t;

    function automatic vec_t mk(logic [1:0] r, logic vb, logic [1:0] cv, logic [1:0] we,
                                logic [15:0] x0, logic [15:0] x1, logic [7:0] wd,
                                logic [1:0] eg_, logic ecp, logic ewe_, logic [1:0] erv,
                                logic [15:0] ea, logic [7:0] ew, logic [7:0] erd);
        vec_t v;
        v.req = r; v.vb = vb; v.cv = cv; v.we = we; v.a0 = x0; v.a1 = x1; v.wd = wd;
        v.e_gnt = eg_; v.e_cp = ecp; v.e_we = ewe_; v.e_rv = erv;
        v.e_addr = ea; v.e_wd = ew; v.e_rd = erd;
        return v;
    endfunction

    vec_t vt [16];
    int   n;

    initial begin
        // Row k: inputs for cycle k after reset, outputs expected in cycle k+1
        vt[0]  = mk(2'b01, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00,
                    2'b00, 1, 0, 2'b00, 16'h0000, 8'h00, 8'h00);
        vt[1]  = vt[0];
        vt[2]  = mk(2'b01, 0, 2'b01, 2'b01, 16'hBEEF, 16'h0000, 8'hAA,
                    2'b00, 1, 0, 2'b00, 16'h0000, 8'h00, 8'h00);
        vt[3]  = mk(2'b01, 0, 2'b01, 2'b00, 16'hBEEF, 16'h0000, 8'hAA,
                    2'b00, 1, 0, 2'b00, 16'h0000, 8'h00, 8'h00);
        vt[4]  = vt[0];
        vt[5]  = mk(2'b01, 1, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00,
                    2'b00, 1, 0, 2'b00, 16'h0000, 8'h00, 8'h00);
        vt[6]  = vt[0];
        vt[7]  = vt[0];
        vt[8]  = vt[0];
        vt[9]  = mk(2'b01, 0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00,
                    2'b01, 1, 0, 2'b00, 16'h0000, 8'h00, 8'h00);
        vt[10] = mk(2'b01, 0, 2'b01, 2'b01, 16'h43A5, 16'h0000, 8'h7E,
                    2'b01, 1, 1, 2'b00, 16'h43A5, 8'h7E, 8'h00);
        vt[11] = mk(2'b01, 0, 2'b01, 2'b00, 16'h43A5, 16'h0000, 8'h00,
                    2'b01, 1, 0, 2'b00, 16'h43A5, 8'h00, 8'h00);
        vt[12] = mk(2'b01, 0, 2'b00, 2'b00, 16'h43A5, 16'h0000, 8'h00,
                    2'b01, 1, 0, 2'b01, 16'h43A5, 8'h00, 8'h7E);
        vt[13] = mk(2'b01, 0, 2'b10, 2'b10, 16'h0000, 16'h1111, 8'h55,
                    2'b01, 1, 0, 2'b00, 16'h43A5, 8'h00, 8'h00);
        vt[14] = mk(2'b01, 0, 2'b10, 2'b00, 16'h0000, 16'h1111, 8'h55,
                    2'b01, 1, 0, 2'b00, 16'h43A5, 8'h00, 8'h00);
        vt[15] = mk(2'b01, 0, 2'b00, 2'b00, 16'h0000, 16'h1111, 8'h55,
                    2'b01, 1, 0, 2'b00, 16'h43A5, 8'h00, 8'h00);

        tick();
        do_reset();

        // Pause, vblank, settle, grant, then write/read and ignored commands
        for (int k = 0; k < 16; k++) begin
            req = vt[k].req; vblank = vt[k].vb; cmd_valid = vt[k].cv; cmd_we = vt[k].we;
            cmd_addr = {vt[k].a1, vt[k].a0};
            cmd_wdata = {vt[k].wd, vt[k].wd};
            tick();
            chk($sformatf("vec%0d", k), {g1, cp1, we1, rv1, a1, wd1},
                {vt[k].e_gnt, vt[k].e_cp, vt[k].e_we, vt[k].e_rv, vt[k].e_addr, vt[k].e_wd});
            if (vt[k].e_rv != 2'b00) chk($sformatf("vec%0d_rd", k), rd1, vt[k].e_rd);
        end

        // Owner drops req in the same cycle as a read; RD_LAT 3 drain length
        req = 2'b00; cmd_valid = 2'b01; cmd_we = 2'b00; cmd_addr = {16'h0, 16'h43A5};
        tick();
        cmd_valid = 2'b00;
        n = 1;
        while (rv3 != 2'b01 && n < 8) begin
            chk("t4_drain_pause", {g3, cp3}, 3'b001);
            tick();
            n++;
        end
        chk("t4_drain_len", n, 4);
        chk("t4_rd_data", rd3, 8'h7E);
        tick();
        chk("t4_idle", {g3, cp3}, 3'b000);

        // Both request after reset: req 0 first, direct hand-over to req 1
        do_reset();
        get_grant(2'b11, 2'b01, "t3_first_grant");
        req = 2'b10;
        tick();
        chk("t3_drain", {g1, cp1}, 3'b001);
        tick();
        chk("t3_handover", {g1, cp1}, 3'b101);
        req = 2'b00;
        tick();
        tick();
        chk("t3_release", {g1, cp1}, 3'b000);
        get_grant(2'b01, 2'b01, "rr_single0");
        req = 2'b00;
        tick();
        tick();
        get_grant(2'b11, 2'b10, "rr_both_after0");
        req = 2'b00;
        tick();
        tick();

        // core_pause follows ext_pause without a clock edge
        ext_pause = 1'b1;
        #1 chk("ext_pause_comb_hi", cp1, 1'b1);
        ext_pause = 1'b0;
        #1 chk("ext_pause_comb_lo", cp1, 1'b0);

        // Reset mid-GRANT with a read in flight
        get_grant(2'b01, 2'b01, "t6_grant");
        cmd_valid = 2'b01; cmd_we = 2'b00; cmd_addr = {16'h0, 16'h0042};
        tick();
        cmd_valid = 2'b00;
        ext_pause = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_rd", {rv1, rv3, g1, cp1}, 7'b0000001);
        end
        ext_pause = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) req[0] = ~req[0];
            if ($urandom_range(7) == 0) req[1] = ~req[1];
            vblank = ($urandom_range(5) == 0);
            if ($urandom_range(40) == 0) ext_pause = ~ext_pause;
            cmd_valid = 2'($urandom);
            cmd_we = 2'($urandom);
            cmd_addr = {16'h0A00 | 16'($urandom_range(15)), 16'h0A00 | 16'($urandom_range(15))};
            cmd_wdata = 16'($urandom);
            reset_n = ($urandom_range(499) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
